mem_bus_responder: RTL and testbench

- Memory and I/O responder for the 6502 core: the slave end of the CPU bus.
- Each bus cycle it decodes `A_BUS`/`RW` and serves reads from internal RAM, loadable ROM, or a small I/O register file; writes go to RAM or I/O.
- It inserts programmable wait states by dropping `RDY`, and raises `IRQ_N` from an internal interval timer.
- It sits beside `CPU` in the system top and is the only device on the bus.

---
 rtl/bus_map_pkg.sv | 46 ++++
 rtl/bus_timer.sv | 62 ++++++
 rtl/mem_bus_responder.sv | 151 +++++++++++++++
 tb/tb_mem_bus_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_map_pkg.sv
// Shared address map, I/O register offsets, control bit positions and bus FSM
// encoding for the 6502 memory/I-O responder.
package bus_map_pkg;

    localparam int unsigned RAM_BASE       = 'h0000;
    localparam int unsigned RAM_SPAN       = 'h4000;
    localparam int unsigned IO_REGION_BASE = 'h4000;
    localparam int unsigned IO_SPAN        = 'h4000;
    localparam int unsigned ROM_BASE       = 'h8000;
    localparam int unsigned ROM_SPAN       = 'h8000;

    localparam logic [1:0] IO_GPIO = 2'd0;
    localparam logic [1:0] IO_TMR  = 2'd1;
    localparam logic [1:0] IO_CTRL = 2'd2;
    localparam logic [1:0] IO_STAT = 2'd3;

    localparam int CTRL_TMR_EN  = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int STAT_EXPIRED = 0;
    localparam logic [7:0] CTRL_MASK = 8'h03;

    typedef enum logic [1:0] {
        REG_RAM = 2'd0,
        REG_IO  = 2'd1,
        REG_ROM = 2'd2
    } region_e;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_WAIT = 1'b1
    } bus_state_e;

    // Unsigned offset compare keeps each window check a single comparison.
    function automatic region_e decode_region(input logic [15:0] addr);
        int unsigned a;
        a = 32'(addr);
        if (a - RAM_BASE < RAM_SPAN)
            return REG_RAM;
        if (a - IO_REGION_BASE < IO_SPAN)
            return REG_IO;
        if (a - ROM_BASE < ROM_SPAN)
            return REG_ROM;
        return REG_ROM;
    endfunction

endpackage

// File: rtl/bus_timer.sv
// Interval timer for the I/O window: reload/count registers, enable edge
// detect, sticky expired flag with set-over-clear priority, registered IRQ_N.
module bus_timer
    import bus_map_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic       wr_en,
    input  logic [1:0] wr_off,
    input  logic [7:0] wr_data,
    output logic [7:0] count,
    output logic [7:0] ctrl,
    output logic       expired,
    output logic       irq_n
);

    logic [7:0] reload_reg;
    logic [7:0] count_reg;
    logic [7:0] ctrl_reg;
    logic       expired_reg;
    logic       irq_n_reg;

    logic ctrl_wr;
    logic enable_rise;
    logic expire_set;
    logic stat_clear;

    always_comb begin
        ctrl_wr     = wr_en && (wr_off == IO_CTRL);
        enable_rise = ctrl_wr && wr_data[CTRL_TMR_EN] && !ctrl_reg[CTRL_TMR_EN];
        expire_set  = ctrl_reg[CTRL_TMR_EN] && (count_reg == 8'd0);
        stat_clear  = wr_en && (wr_off == IO_STAT) && wr_data[STAT_EXPIRED];
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            reload_reg  <= 8'd0;
            count_reg   <= 8'd0;
            ctrl_reg    <= 8'd0;
            expired_reg <= 1'b0;
            irq_n_reg   <= 1'b1;
        end else begin
            if (wr_en && (wr_off == IO_TMR))
                reload_reg <= wr_data;
            if (ctrl_wr)
                ctrl_reg <= wr_data & CTRL_MASK;
            // Count never underflows: zero always reloads while enabled.
            if (enable_rise)
                count_reg <= reload_reg;
            else if (ctrl_reg[CTRL_TMR_EN])
                count_reg <= expire_set ? reload_reg : count_reg - 8'd1;
            expired_reg <= expire_set || (expired_reg && !stat_clear);
            irq_n_reg   <= !(expired_reg && ctrl_reg[CTRL_IRQ_EN]);
        end
    end

    assign count   = count_reg;
    assign ctrl    = ctrl_reg;
    assign expired = expired_reg;
    assign irq_n   = irq_n_reg;

endmodule

// File: rtl/mem_bus_responder.sv
// Slave end of the 6502 bus: RAM, loadable ROM and a 4-byte I/O window, with
// programmable wait states and a timer interrupt.
module mem_bus_responder
    import bus_map_pkg::*;
#(
    parameter int          RAM_AW      = 11,
    parameter int          ROM_AW      = 12,
    parameter logic [15:0] IO_BASE     = 16'h4000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [15:0] A_BUS,
    input  logic        RW,
    input  logic [7:0]  D_IN,
    output logic [7:0]  D_OUT,
    output logic        RDY,
    output logic        IRQ_N,
    output logic [7:0]  GPIO_OUT,
    input  logic        ld_we,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_data
);

    logic [7:0] ram [2**RAM_AW];
    logic [7:0] rom [2**ROM_AW];

    bus_state_e state_reg, state_next;
    logic [2:0] wcnt_reg, wcnt_next;
    logic [7:0] d_out_reg;
    logic [7:0] gpio_reg;

    region_e     cpu_region, ld_region;
    logic        capture, cpu_wr, io_wr;
    logic [1:0]  io_off;
    logic [7:0]  io_rdata;
    logic        ram_we, rom_we;
    logic [RAM_AW-1:0] ram_waddr;
    logic [7:0]  mem_wdata;
    logic [7:0]  tmr_count, tmr_ctrl;
    logic        tmr_expired;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{A_BUS, ld_addr};

    always_comb begin
        cpu_region = decode_region(A_BUS);
        ld_region  = decode_region(ld_addr);
        io_off     = A_BUS[1:0] - IO_BASE[1:0];
        capture    = (state_reg == BUS_IDLE) && !RST;
        cpu_wr     = capture && !RW;
        io_wr      = cpu_wr && (cpu_region == REG_IO);
    end

    // Reset owns the single write port so the load path always beats the CPU.
    always_comb begin
        ram_we    = RST ? (ld_we && (ld_region == REG_RAM))
                        : (cpu_wr && (cpu_region == REG_RAM));
        ram_waddr = RST ? ld_addr[RAM_AW-1:0] : A_BUS[RAM_AW-1:0];
        rom_we    = RST && ld_we && (ld_region == REG_ROM);
        mem_wdata = RST ? ld_data : D_IN;
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            ram[ram_waddr] <= mem_wdata;
        if (rom_we)
            rom[ld_addr[ROM_AW-1:0]] <= mem_wdata;
    end

    always_comb begin
        io_rdata = 8'd0;
        case (io_off)
            IO_GPIO: io_rdata = gpio_reg;
            IO_TMR:  io_rdata = tmr_count;
            IO_CTRL: io_rdata = tmr_ctrl;
            IO_STAT: io_rdata = {7'd0, tmr_expired};
            default: io_rdata = 8'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            d_out_reg <= 8'd0;
        end else if (capture && RW) begin
            case (cpu_region)
                REG_RAM: d_out_reg <= ram[A_BUS[RAM_AW-1:0]];
                REG_ROM: d_out_reg <= rom[A_BUS[ROM_AW-1:0]];
                default: d_out_reg <= io_rdata;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (RST)
            gpio_reg <= 8'd0;
        else if (io_wr && (io_off == IO_GPIO))
            gpio_reg <= D_IN;
    end

    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        case (state_reg)
            BUS_IDLE: begin
                if (WAIT_STATES > 0) begin
                    state_next = BUS_WAIT;
                    wcnt_next  = 3'(WAIT_STATES);
                end
            end
            BUS_WAIT: begin
                wcnt_next = wcnt_reg - 3'd1;
                if (wcnt_reg <= 3'd1) begin
                    state_next = BUS_IDLE;
                    wcnt_next  = 3'd0;
                end
            end
            default: begin
                state_next = BUS_IDLE;
                wcnt_next  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_reg <= BUS_IDLE;
            wcnt_reg  <= 3'd0;
        end else begin
            state_reg <= state_next;
            wcnt_reg  <= wcnt_next;
        end
    end

    bus_timer u_timer (
        .clk     (clk),
        .srst    (RST),
        .wr_en   (io_wr),
        .wr_off  (io_off),
        .wr_data (D_IN),
        .count   (tmr_count),
        .ctrl    (tmr_ctrl),
        .expired (tmr_expired),
        .irq_n   (IRQ_N)
    );

    assign D_OUT    = d_out_reg;
    assign RDY      = !((state_reg == BUS_WAIT) && (wcnt_reg != 3'd0));
    assign GPIO_OUT = gpio_reg;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: three instances (0, 2 and 3 wait
// states) share one bus; each sequence checks the instance it targets.
module tb_mem_bus_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rw, ld_we;
    logic [15:0] a_bus, ld_addr;
    logic [7:0]  d_in, ld_data;

    logic [7:0] d_out0, d_out2, d_out3;
    logic [7:0] gpio0, gpio2, gpio3;
    logic       rdy0, rdy2, rdy3;
    logic       irq_n0, irq_n2, irq_n3;

    int checks = 0;
    int errors = 0;

    mem_bus_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .RST(rst), .A_BUS(a_bus), .RW(rw), .D_IN(d_in),
        .D_OUT(d_out0), .RDY(rdy0), .IRQ_N(irq_n0), .GPIO_OUT(gpio0),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    mem_bus_responder #(.WAIT_STATES(2)) u_ws2 (
        .clk(clk), .RST(rst), .A_BUS(a_bus), .RW(rw), .D_IN(d_in),
        .D_OUT(d_out2), .RDY(rdy2), .IRQ_N(irq_n2), .GPIO_OUT(gpio2),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    mem_bus_responder #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .RST(rst), .A_BUS(a_bus), .RW(rw), .D_IN(d_in),
        .D_OUT(d_out3), .RDY(rdy3), .IRQ_N(irq_n3), .GPIO_OUT(gpio3),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  wdata;
        logic [7:0]  exp_dout;
        logic [7:0]  exp_gpio;
    } vec_t;

    vec_t vecs[17];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        a_bus = addr;
        rw    = 1'b0;
        d_in  = data;
        tick();
        rw    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_cnt [5];
        logic       exp_irq [5];

        vecs[0]  = '{16'h8000, 1'b1, 8'h00, 8'hA9, 8'h00};
        vecs[1]  = '{16'hF010, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[2]  = '{16'h0810, 1'b1, 8'h00, 8'h42, 8'h00};
        vecs[3]  = '{16'h9000, 1'b0, 8'h77, 8'h42, 8'h00};
        vecs[4]  = '{16'h9000, 1'b1, 8'h00, 8'hA9, 8'h00};
        vecs[5]  = '{16'h4000, 1'b0, 8'h3C, 8'hA9, 8'h3C};
        vecs[6]  = '{16'h4004, 1'b1, 8'h00, 8'h3C, 8'h3C};
        vecs[7]  = '{16'h3FFF, 1'b0, 8'h11, 8'h3C, 8'h3C};
        vecs[8]  = '{16'h07FF, 1'b1, 8'h00, 8'h11, 8'h3C};
        vecs[9]  = '{16'h0123, 1'b0, 8'h99, 8'h11, 8'h3C};
        vecs[10] = '{16'h2123, 1'b1, 8'h00, 8'h99, 8'h3C};
        vecs[11] = '{16'h4002, 1'b0, 8'hFC, 8'h99, 8'h3C};
        vecs[12] = '{16'h4002, 1'b1, 8'h00, 8'h00, 8'h3C};
        vecs[13] = '{16'h4003, 1'b1, 8'h00, 8'h00, 8'h3C};
        vecs[14] = '{16'h4006, 1'b0, 8'h02, 8'h00, 8'h3C};
        vecs[15] = '{16'h4002, 1'b1, 8'h00, 8'h02, 8'h3C};
        vecs[16] = '{16'h0010, 1'b1, 8'h00, 8'h42, 8'h3C};

        exp_cnt = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
        exp_irq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset with a conflicting CPU write on the bus; the load port must win.
        rst = 1'b1; rw = 1'b0; a_bus = 16'h0010; d_in = 8'hEE;
        ld_we = 1'b0; ld_addr = 16'h0000; ld_data = 8'h00;
        tick();
        tick();
        check8("rst_dout", d_out0, 8'h00);
        check1("rst_rdy", rdy0, 1'b1);
        check1("rst_irq_n", irq_n0, 1'b1);
        check8("rst_gpio", gpio0, 8'h00);
        check1("rst_rdy_ws2", rdy2, 1'b1);
        check1("rst_irq_n_ws2", irq_n2, 1'b1);
        check8("rst_gpio_ws2", gpio2, 8'h00);

        ld_we = 1'b1;
        ld_addr = 16'h8000; ld_data = 8'hA9; tick();
        ld_addr = 16'h0010; ld_data = 8'h42; tick();
        ld_addr = 16'h8010; ld_data = 8'h00; tick();
        ld_addr = 16'h4000; ld_data = 8'h55; tick();
        ld_we = 1'b0;
        check8("ld_io_ignored", gpio0, 8'h00);

        rst = 1'b0; rw = 1'b1; a_bus = 16'h0000; d_in = 8'h00;

        for (int i = 0; i < 17; i++) begin
            a_bus = vecs[i].addr;
            rw    = vecs[i].rw;
            d_in  = vecs[i].wdata;
            tick();
            $display("vec %0d addr=%04h rw=%0d wdata=%02h dout=%02h gpio=%02h",
                     i, vecs[i].addr, vecs[i].rw, vecs[i].wdata, d_out0, gpio0);
            check8($sformatf("vec%0d_dout", i), d_out0, vecs[i].exp_dout);
            check8($sformatf("vec%0d_gpio", i), gpio0, vecs[i].exp_gpio);
        end
        rw = 1'b1;

        // Timer: reload 3, then enable with IRQ; expiry edge is 4 cycles later.
        bus_write(16'h4001, 8'h03);
        bus_write(16'h4002, 8'h03);
        a_bus = 16'h4001;
        for (int i = 0; i < 5; i++) begin
            tick();
            $display("timer cycle %0d count_read=%02h irq_n=%b", i + 1, d_out0, irq_n0);
            check8($sformatf("tmr_count_%0d", i + 1), d_out0, exp_cnt[i]);
            check1($sformatf("tmr_irq_n_%0d", i + 1), irq_n0, exp_irq[i]);
        end

        bus_write(16'h4003, 8'h01);
        a_bus = 16'h4003;
        tick();
        check1("clr_irq_n_e7", irq_n0, 1'b1);
        check8("clr_stat_e7", d_out0, 8'h00);
        tick();
        check1("clr_irq_n_e8", irq_n0, 1'b1);
        tick();
        check1("reassert_irq_n_e9", irq_n0, 1'b0);
        check8("reassert_stat_e9", d_out0, 8'h01);

        // Clear early, then clear again on exactly the next expiry edge.
        bus_write(16'h4003, 8'h01);
        tick();
        check1("preclr_irq_n_e11", irq_n0, 1'b1);
        bus_write(16'h4003, 8'h01);
        a_bus = 16'h4003;
        tick();
        $display("set-vs-clear stat=%02h irq_n=%b", d_out0, irq_n0);
        check1("setclr_irq_n", irq_n0, 1'b0);
        check8("setclr_stat", d_out0, 8'h01);

        // Two wait states: D_IN is changed mid-stall to expose any resampling.
        for (int i = 0; i < 8 && rdy2 !== 1'b1; i++) tick();
        check1("ws2_align", rdy2, 1'b1);
        a_bus = 16'h0020; rw = 1'b0; d_in = 8'h5A;
        tick();
        check1("ws2_rdy_w1", rdy2, 1'b0);
        d_in = 8'hEE;
        tick();
        check1("ws2_rdy_w2", rdy2, 1'b0);
        tick();
        check1("ws2_rdy_back", rdy2, 1'b1);
        rw = 1'b1;
        tick();
        $display("ws2 read 0020 dout=%02h rdy=%b", d_out2, rdy2);
        check8("ws2_read", d_out2, 8'h5A);
        check1("ws2_read_rdy", rdy2, 1'b0);

        // Three wait states: reset lands in the middle of a GPIO write stall.
        for (int i = 0; i < 10 && rdy3 !== 1'b1; i++) tick();
        check1("ws3_align", rdy3, 1'b1);
        a_bus = 16'h4000; rw = 1'b0; d_in = 8'h33;
        tick();
        check8("ws3_gpio_w", gpio3, 8'h33);
        check1("ws3_rdy_w1", rdy3, 1'b0);
        tick();
        check1("ws3_rdy_w2", rdy3, 1'b0);
        rst = 1'b1; rw = 1'b1;
        tick();
        check1("ws3_rst_rdy", rdy3, 1'b1);
        check8("ws3_rst_dout", d_out3, 8'h00);
        check8("ws3_rst_gpio", gpio3, 8'h00);
        check1("ws3_rst_irq_n", irq_n3, 1'b1);
        rst = 1'b0;
        tick();
        $display("ws3 after reset gpio=%02h dout=%02h", gpio3, d_out3);
        check8("ws3_no_recommit", gpio3, 8'h00);
        check8("ws3_read_gpio", d_out3, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
